// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 slave.
// Imported by the synchroniser and the top level.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_if.sv
// Fabric-side valid/ready bundle of the SPI slave.
// master = fabric logic, slave = spi_slave.
interface spi_slave_if #(
    parameter int WORD = 8
);
    logic [WORD-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [WORD-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-FF synchroniser for an async pin plus rise/fall detect.
// The extra delay register makes edges visible one cycle after sync.
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    // next values of the synchroniser chain and edge delay register
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // synchroniser and delay registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~dly_q;
    assign fall = ~dout & dly_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled on refCLK.
// Deserialises MOSI to rx words, serialises tx words onto MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int              WORD         = 8,
    parameter logic [WORD-1:0] IDLE_PATTERN = '1
) (
    input  logic          refCLK,
    input  logic          reset,
    input  logic          SCLK,
    input  logic          SSN,
    input  logic          MOSI,
    output logic          MISO,
    output logic          MISO_oe,
    spi_slave_if.slave    bus,
    output logic          rx_overrun,
    output logic          tx_underrun,
    output logic          busy
);
    localparam int            CW   = $clog2(WORD);
    localparam logic [CW-1:0] LAST = CW'(WORD - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ssn_s, ssn_rise, ssn_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_sclk (
        .clk (refCLK), .rst (reset), .din (SCLK),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge u_ssn (
        .clk (refCLK), .rst (reset), .din (SSN),
        .dout(ssn_s), .rise(ssn_rise), .fall(ssn_fall)
    );

    spi_sync_edge u_mosi (
        .clk (refCLK), .rst (reset), .din (MOSI),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_slv_state_t  state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD-1:0] rx_shift_q, rx_shift_d;
    logic [WORD-1:0] tx_shift_q, tx_shift_d;
    logic [WORD-1:0] tx_buf_q, tx_buf_d;
    logic            tx_full_q, tx_full_d;
    logic [WORD-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d;
    logic            underrun_q, underrun_d;
    logic            reload;
    logic [WORD-1:0] rx_word;

    assign rx_word = {rx_shift_q[WORD-2:0], mosi_s};

    // frame FSM, shifters, tx buffer and rx holding register
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        underrun_d = 1'b0;
        reload     = 1'b0;

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (ssn_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssn_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word;
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d = '0;
                        if (!rx_valid_q || bus.rx_ready) begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shift_q << 1;
                    end else begin
                        reload = 1'b1;
                    end
                end
            end
        endcase

        // word boundary: take the buffered word or underrun
        if (reload) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = IDLE_PATTERN;
                underrun_d = 1'b1;
            end
        end

        // a write racing an underrun reload still lands
        if (bus.tx_valid && !tx_full_q) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge refCLK) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign busy         = (state_q == ACTIVE);
    assign MISO_oe      = busy;
    assign MISO         = tx_shift_q[WORD-1];
    assign bus.tx_ready = ~tx_full_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign rx_overrun   = overrun_q;
    assign tx_underrun  = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: SPI mode-0 master model, fabric model and
// queue-based expectations derived from the frame rules.
module tb_spi_slave;
    logic refCLK = 1'b0;
    logic reset, SCLK, SSN, MOSI;
    logic MISO, MISO_oe, rx_overrun, tx_underrun, busy;

    spi_slave_if #(.WORD(8)) bus ();

    spi_slave #(.WORD(8), .IDLE_PATTERN(8'hFF)) dut (
        .refCLK(refCLK), .reset(reset), .SCLK(SCLK), .SSN(SSN),
        .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .busy(busy)
    );

    always #5 refCLK = ~refCLK;

    int checks = 0;
    int errors = 0;
    int underrun_cnt = 0;
    int overrun_cnt = 0;
    logic [7:0] rx_got[$];
    logic [7:0] miso_got[$];
    logic [7:0] mosi_q[$];

    // fabric-side observer: accepted rx words and status pulses
    always @(negedge refCLK) begin
        #1;
        if (bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
        if (tx_underrun) underrun_cnt++;
        if (rx_overrun) overrun_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tx_write(input logic [7:0] d);
        int n = 0;
        @(negedge refCLK);
        while (!bus.tx_ready && n < 400) begin
            @(negedge refCLK);
            n++;
        end
        checks++;
        if (!bus.tx_ready) begin
            errors++;
            $display("FAIL tx_write_wait: tx_ready=%b required 1", bus.tx_ready);
        end else begin
            bus.tx_data  = d;
            bus.tx_valid = 1'b1;
            @(negedge refCLK);
            bus.tx_valid = 1'b0;
        end
    endtask

    // master: SCLK = refCLK/8, final falling edge coincides with SSN rise
    task automatic spi_frame(input int abort_bits);
        int total;
        int w;
        int b;
        logic [7:0] m = 8'h00;
        total = (abort_bits != 0) ? abort_bits : mosi_q.size() * 8;
        @(negedge refCLK);
        SSN = 1'b0;
        repeat (6) @(negedge refCLK);
        for (int i = 0; i < total; i++) begin
            w = i / 8;
            b = 7 - (i % 8);
            MOSI = mosi_q[w][b];
            repeat (4) @(negedge refCLK);
            m = {m[6:0], MISO};
            SCLK = 1'b1;
            repeat (4) @(negedge refCLK);
            SCLK = 1'b0;
            if (i == total - 1) SSN = 1'b1;
            if (i % 8 == 7) miso_got.push_back(m);
        end
        MOSI = 1'b0;
        repeat (10) @(negedge refCLK);
        mosi_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        SCLK = 1'b0; SSN = 1'b1; MOSI = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
        repeat (3) @(negedge refCLK);
        reset = 1'b0;
        repeat (2) @(negedge refCLK);
        checks++;
        if ({MISO, MISO_oe, bus.tx_ready, bus.rx_valid, rx_overrun,
             tx_underrun, busy} !== 7'b0010000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0010000",
                     {MISO, MISO_oe, bus.tx_ready, bus.rx_valid,
                      rx_overrun, tx_underrun, busy});
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required 00", bus.rx_data);
        end
    endtask

    task automatic test_basic;
        int r0 = rx_got.size();
        int u0 = underrun_cnt;
        logic [7:0] got;
        bus.rx_ready = 1'b0;
        tx_write(8'hA5);
        mosi_q.push_back(8'h3C);
        spi_frame(0);
        got = (miso_got.size() > 0) ? miso_got.pop_front() : 8'hxx;
        checks++;
        if (got !== 8'hA5) begin
            errors++; $display("FAIL basic_miso: got %h required a5", got);
        end
        repeat (20) @(negedge refCLK);
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL basic_rx_hold: valid=%b data=%h required 1/3c",
                     bus.rx_valid, bus.rx_data);
        end
        bus.rx_ready = 1'b1;
        repeat (2) @(negedge refCLK);
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++; $display("FAIL basic_rx_clear: got %b required 0", bus.rx_valid);
        end
        checks++;
        if (rx_got.size() != r0 + 1 || rx_got[r0] !== 8'h3C) begin
            errors++; $display("FAIL basic_rx_accept: count %0d required 1", rx_got.size() - r0);
        end
        checks++;
        if (underrun_cnt != u0) begin
            errors++; $display("FAIL basic_underrun: got %0d required 0", underrun_cnt - u0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] tx_exp[3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] rx_exp[3] = '{8'hF0, 8'h0F, 8'hAA};
        int r0 = rx_got.size();
        int u0 = underrun_cnt;
        logic [7:0] got;
        bus.rx_ready = 1'b1;
        tx_write(8'h01);
        for (int i = 0; i < 3; i++) mosi_q.push_back(rx_exp[i]);
        fork
            spi_frame(0);
            begin
                tx_write(8'h02);
                tx_write(8'h03);
            end
        join
        for (int i = 0; i < 3; i++) begin
            got = (miso_got.size() > 0) ? miso_got.pop_front() : 8'hxx;
            checks++;
            if (got !== tx_exp[i]) begin
                errors++; $display("FAIL b2b_miso%0d: got %h required %h", i, got, tx_exp[i]);
            end
            got = (rx_got.size() > r0 + i) ? rx_got[r0 + i] : 8'hxx;
            checks++;
            if (got !== rx_exp[i]) begin
                errors++; $display("FAIL b2b_rx%0d: got %h required %h", i, got, rx_exp[i]);
            end
        end
        checks++;
        if (underrun_cnt != u0) begin
            errors++; $display("FAIL b2b_underrun: got %0d required 0", underrun_cnt - u0);
        end
    endtask

    task automatic test_underrun;
        int r0 = rx_got.size();
        int u0 = underrun_cnt;
        logic [7:0] w = 8'($urandom);
        logic [7:0] got;
        bus.rx_ready = 1'b1;
        mosi_q.push_back(w);
        spi_frame(0);
        got = (miso_got.size() > 0) ? miso_got.pop_front() : 8'hxx;
        checks++;
        if (got !== 8'hFF) begin
            errors++; $display("FAIL underrun_miso: got %h required ff", got);
        end
        checks++;
        if (underrun_cnt != u0 + 1) begin
            errors++; $display("FAIL underrun_pulses: got %0d required 1", underrun_cnt - u0);
        end
        got = (rx_got.size() > r0) ? rx_got[r0] : 8'hxx;
        checks++;
        if (got !== w) begin
            errors++; $display("FAIL underrun_rx: got %h required %h", got, w);
        end
    endtask

    task automatic test_overrun;
        int r0 = rx_got.size();
        int o0 = overrun_cnt;
        bus.rx_ready = 1'b0;
        mosi_q.push_back(8'h11);
        mosi_q.push_back(8'h22);
        spi_frame(0);
        void'(miso_got.pop_front());
        void'(miso_got.pop_front());
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold: valid=%b data=%h required 1/11",
                     bus.rx_valid, bus.rx_data);
        end
        checks++;
        if (overrun_cnt != o0 + 1) begin
            errors++; $display("FAIL overrun_pulses: got %0d required 1", overrun_cnt - o0);
        end
        bus.rx_ready = 1'b1;
        repeat (4) @(negedge refCLK);
        checks++;
        if (rx_got.size() != r0 + 1 || rx_got[r0] !== 8'h11) begin
            errors++; $display("FAIL overrun_accept: count %0d required 1", rx_got.size() - r0);
        end
    endtask

    task automatic test_abort;
        int r0 = rx_got.size();
        logic [7:0] got;
        bus.rx_ready = 1'b1;
        mosi_q.push_back(8'hC3);
        spi_frame(5);
        checks++;
        if (rx_got.size() != r0 || bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_partial: words %0d valid %b required 0/0",
                     rx_got.size() - r0, bus.rx_valid);
        end
        checks++;
        if (busy !== 1'b0 || MISO_oe !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b oe=%b required 0/0", busy, MISO_oe);
        end
        mosi_q.push_back(8'h5A);
        spi_frame(0);
        void'(miso_got.pop_front());
        got = (rx_got.size() > r0) ? rx_got[r0] : 8'hxx;
        checks++;
        if (got !== 8'h5A || bus.rx_data !== 8'h5A) begin
            errors++; $display("FAIL abort_next: got %h data %h required 5a", got, bus.rx_data);
        end
    endtask

    task automatic test_reset_mid;
        int r0;
        logic [7:0] w = 8'($urandom);
        logic [7:0] got;
        bus.rx_ready = 1'b1;
        tx_write(8'h9C);
        @(negedge refCLK);
        SSN = 1'b0;
        repeat (6) @(negedge refCLK);
        tx_write(8'h4D);
        for (int i = 0; i < 3; i++) begin
            MOSI = i[0];
            repeat (4) @(negedge refCLK);
            SCLK = 1'b1;
            repeat (4) @(negedge refCLK);
            SCLK = 1'b0;
        end
        reset = 1'b1;
        @(negedge refCLK);
        reset = 1'b0;
        checks++;
        if ({MISO, MISO_oe, bus.tx_ready, bus.rx_valid, rx_overrun,
             tx_underrun, busy} !== 7'b0010000) begin
            errors++;
            $display("FAIL midreset_flags: got %b required 0010000",
                     {MISO, MISO_oe, bus.tx_ready, bus.rx_valid,
                      rx_overrun, tx_underrun, busy});
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++; $display("FAIL midreset_rx_data: got %h required 00", bus.rx_data);
        end
        SSN = 1'b1;
        MOSI = 1'b0;
        repeat (10) @(negedge refCLK);
        r0 = rx_got.size();
        mosi_q.push_back(w);
        spi_frame(0);
        got = (miso_got.size() > 0) ? miso_got.pop_front() : 8'hxx;
        checks++;
        if (got !== 8'hFF) begin
            errors++; $display("FAIL midreset_miso: got %h required ff", got);
        end
        got = (rx_got.size() > r0) ? rx_got[r0] : 8'hxx;
        checks++;
        if (got !== w) begin
            errors++; $display("FAIL midreset_rx: got %h required %h", got, w);
        end
    endtask

    task automatic test_random;
        int n;
        int r0;
        int u0;
        int o0;
        bit pre;
        logic [7:0] tw;
        logic [7:0] rx_exp[$];
        logic [7:0] tx_exp[$];
        logic [7:0] got;
        bus.rx_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 3);
            pre = 1'($urandom);
            tw = 8'($urandom);
            rx_exp.delete();
            tx_exp.delete();
            for (int i = 0; i < n; i++) begin
                rx_exp.push_back(8'($urandom));
                tx_exp.push_back((i == 0 && pre) ? tw : 8'hFF);
            end
            if (pre) tx_write(tw);
            r0 = rx_got.size();
            u0 = underrun_cnt;
            o0 = overrun_cnt;
            foreach (rx_exp[i]) mosi_q.push_back(rx_exp[i]);
            spi_frame(0);
            for (int i = 0; i < n; i++) begin
                got = (miso_got.size() > 0) ? miso_got.pop_front() : 8'hxx;
                checks++;
                if (got !== tx_exp[i]) begin
                    errors++;
                    $display("FAIL rand_miso f%0d w%0d: got %h required %h", f, i, got, tx_exp[i]);
                end
                got = (rx_got.size() > r0 + i) ? rx_got[r0 + i] : 8'hxx;
                checks++;
                if (got !== rx_exp[i]) begin
                    errors++;
                    $display("FAIL rand_rx f%0d w%0d: got %h required %h", f, i, got, rx_exp[i]);
                end
            end
            checks++;
            if (underrun_cnt - u0 != (pre ? 0 : 1) + n - 1 || overrun_cnt != o0) begin
                errors++;
                $display("FAIL rand_pulses f%0d: underrun %0d overrun %0d required %0d/0",
                         f, underrun_cnt - u0, overrun_cnt - o0, (pre ? 0 : 1) + n - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
